// File: rtl/slave_monitor_capture_fifo.sv
// Passive APB-style bus snooper: decodes completed transfers into records and
// buffers them in a first-word-fall-through FIFO with sticky error flags.
module slave_monitor_capture_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    txn_valid,
  input  logic                    txn_ready,
  output logic                    txn_write,
  output logic [ADDR_WIDTH-1:0]   txn_addr,
  output logic [DATA_WIDTH-1:0]   txn_data,
  output logic                    txn_slverr,
  output logic [WAIT_WIDTH-1:0]   txn_wait,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    protocol_err,
  input  logic                    clear_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  slverr;
    logic [WAIT_WIDTH-1:0] wcnt;
  } rec_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic                  push, perr_evt;
  rec_t                  rec;

  rec_t                  mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  rec_t                  head_q, head_d;
  logic                  overflow_q, overflow_d, perr_q, perr_d;
  logic                  full, empty, pop, wr_en, drains_to_empty;

  // SETUP means the setup phase has been seen, so the current bus cycle is the
  // first access cycle; a zero-wait transfer completes directly from SETUP.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    push     = 1'b0;
    perr_evt = 1'b0;
    rec      = '{write: write_q, addr: addr_q,
                 data: write_q ? wdata_q : prdata,
                 slverr: pslverr, wcnt: wait_q};
    if (penable && !psel) begin
      perr_evt = 1'b1;
      state_d  = IDLE;
      wait_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_d = SETUP;
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
          end else if (psel && penable) begin
            perr_evt = 1'b1;
          end
        end
        SETUP, ACCESS: begin
          if (!psel) begin
            perr_evt = 1'b1;
            state_d  = IDLE;
            wait_d   = '0;
          end else if (!penable) begin
            if (state_q == SETUP) begin
              addr_d  = paddr;
              write_d = pwrite;
              wdata_d = pwdata;
            end else begin
              perr_evt = 1'b1;
              state_d  = IDLE;
              wait_d   = '0;
            end
          end else if (paddr != addr_q || pwrite != write_q) begin
            perr_evt = 1'b1;
            state_d  = IDLE;
            wait_d   = '0;
          end else if (pready) begin
            push    = 1'b1;
            state_d = IDLE;
            wait_d  = '0;
          end else begin
            state_d = ACCESS;
            wait_d  = (wait_q == '1) ? wait_q : wait_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    full       = (count_q == CNT_FULL);
    empty      = (count_q == '0);
    pop        = !empty && txn_ready;
    wr_en      = push && (!full || pop);
    overflow_d = (overflow_q && !clear_err) || (push && full && !pop);
    perr_d     = (perr_q && !clear_err) || perr_evt;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_ONE;
    else if (!wr_en && pop) count_d = count_q - CNT_ONE;
    // Registered head: a record landing in an emptied FIFO becomes the head
    // directly; otherwise a pop exposes the next stored entry.
    drains_to_empty = empty || (pop && count_q == CNT_ONE);
    head_d = head_q;
    if (count_d != '0) begin
      if (drains_to_empty)  head_d = rec;
      else if (pop)         head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_ptr_q] <= rec;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
    end
  end

  assign txn_valid    = !empty;
  assign txn_write    = head_q.write;
  assign txn_addr     = head_q.addr;
  assign txn_data     = head_q.data;
  assign txn_slverr   = head_q.slverr;
  assign txn_wait     = head_q.wcnt;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_slave_monitor_capture_fifo.sv
// Randomized bench for slave_monitor_capture_fifo against a queue-based
// transaction model of the captured records.
module tb_slave_monitor_capture_fifo;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int WW = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WMAX = (1 << WW) - 1;

  logic pclk = 1'b0, preset_n = 1'b0;
  logic psel = 0, penable = 0, pwrite = 0, pready = 0, pslverr = 0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0, prdata = '0;
  logic txn_valid, txn_ready = 0, txn_write, txn_slverr, overflow, protocol_err;
  logic clear_err = 0;
  logic [AW-1:0] txn_addr;
  logic [DW-1:0] txn_data;
  logic [WW-1:0] txn_wait;
  logic [CW-1:0] count;

  int errors = 0, checks = 0;

  typedef struct { bit w; logic [AW-1:0] a; logic [DW-1:0] d; bit e; int unsigned wt; } rec_t;
  rec_t exp_q[$];
  bit exp_ovf = 0;

  slave_monitor_capture_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_WIDTH(WW)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_write(txn_write), .txn_addr(txn_addr),
    .txn_data(txn_data), .txn_slverr(txn_slverr), .txn_wait(txn_wait), .count(count),
    .overflow(overflow), .protocol_err(protocol_err), .clear_err(clear_err));

  always #5 pclk = ~pclk;

  task automatic cyc();
    @(posedge pclk); #1;
  endtask

  task automatic bus_idle();
    psel = 0; penable = 0; pready = 0; cyc();
  endtask

  // One complete transfer; the model pops (if asked) then pushes or drops.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int unsigned waits, input bit err, input bit pop_at_end);
    rec_t r;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = w ? d : DW'($urandom); pready = 0;
    cyc();
    penable = 1;
    for (int unsigned i = 0; i < waits; i++) begin
      prdata = $urandom; pslverr = 1'($urandom); cyc();
    end
    pready = 1; pslverr = err; prdata = w ? DW'($urandom) : d;
    txn_ready = pop_at_end;
    r.w = w; r.a = a; r.d = d; r.e = err; r.wt = (waits > WMAX) ? WMAX : waits;
    if (pop_at_end && exp_q.size() != 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(r); else exp_ovf = 1;
    cyc();
    psel = 0; penable = 0; pready = 0; pslverr = 0; txn_ready = 0;
  endtask

  task automatic drain_and_check(input string tag);
    rec_t r;
    while (exp_q.size() != 0) begin
      r = exp_q[0];
      checks++;
      if (count !== CW'(exp_q.size()) || txn_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s drain count/valid: got count=%0d valid=%b want count=%0d valid=1",
                 tag, count, txn_valid, exp_q.size());
      end
      checks++;
      if ({txn_write, txn_addr, txn_data, txn_slverr, txn_wait} !== {r.w, r.a, r.d, r.e, WW'(r.wt)}) begin
        errors++;
        $display("FAIL %s drain record: got w=%b a=%h d=%h e=%b wt=%0d want w=%b a=%h d=%h e=%b wt=%0d",
                 tag, txn_write, txn_addr, txn_data, txn_slverr, txn_wait, r.w, r.a, r.d, r.e, r.wt);
      end
      txn_ready = 1; cyc(); txn_ready = 0;
      void'(exp_q.pop_front());
    end
    checks++;
    if (txn_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL %s drained empty: got valid=%b count=%0d want 0/0", tag, txn_valid, count);
    end
  endtask

  task automatic test_reset();
    preset_n = 0; cyc(); cyc();
    checks++;
    if ({txn_valid, count, overflow, protocol_err} !== '0) begin
      errors++;
      $display("FAIL reset flags: got valid=%b count=%0d ovf=%b perr=%b want all 0",
               txn_valid, count, overflow, protocol_err);
    end
    checks++;
    if ({txn_write, txn_addr, txn_data, txn_slverr, txn_wait} !== '0) begin
      errors++;
      $display("FAIL reset txn outputs: got a=%h d=%h wt=%0d want 0", txn_addr, txn_data, txn_wait);
    end
    preset_n = 1; cyc();
  endtask

  task automatic test_single_write();
    xfer(1, 32'h10, 32'hA5A5_0001, 0, 0, 0);
    checks++;
    if (txn_valid !== 1 || count !== CW'(1) || txn_write !== 1 || txn_addr !== 32'h10 ||
        txn_data !== 32'hA5A5_0001 || txn_wait !== '0) begin
      errors++;
      $display("FAIL single_write: got v=%b cnt=%0d w=%b a=%h d=%h wt=%0d want 1/1/1/10/a5a50001/0",
               txn_valid, count, txn_write, txn_addr, txn_data, txn_wait);
    end
    drain_and_check("single_write");
  endtask

  task automatic test_read_waits();
    xfer(0, 32'h0000_0200, 32'hDEAD_BEEF, 3, 1, 0);
    checks++;
    if (txn_write !== 0 || txn_data !== 32'hDEAD_BEEF || txn_slverr !== 1 || txn_wait !== WW'(3)) begin
      errors++;
      $display("FAIL read_waits: got w=%b d=%h e=%b wt=%0d want 0/deadbeef/1/3",
               txn_write, txn_data, txn_slverr, txn_wait);
    end
    drain_and_check("read_waits");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) xfer(1, AW'($urandom) & ~32'h3, $urandom, 0, 0, 0);
    bus_idle();
    checks++;
    if (count !== CW'(DEPTH) || overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got count=%0d ovf=%b want %0d/1", count, overflow, DEPTH);
    end
    drain_and_check("overflow");
    clear_err = 1; cyc(); clear_err = 0; exp_ovf = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: got ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) xfer($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 2), 0, 0);
    checks++;
    if (count !== CW'(DEPTH) || txn_addr !== exp_q[0].a) begin
      errors++;
      $display("FAIL full_head: got count=%0d a=%h want %0d/%h", count, txn_addr, DEPTH, exp_q[0].a);
    end
    xfer(1, 32'hCAFE_0000, 32'h1234_5678, 1, 0, 1);
    checks++;
    if (count !== CW'(DEPTH) || overflow !== 1'b0 || txn_addr !== exp_q[0].a) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b a=%h want %0d/0/%h",
               count, overflow, txn_addr, DEPTH, exp_q[0].a);
    end
    drain_and_check("full_push_pop");
  endtask

  task automatic test_protocol();
    psel = 1; penable = 1; paddr = 32'h40; cyc();
    bus_idle();
    checks++;
    if (protocol_err !== 1 || count !== '0) begin
      errors++; $display("FAIL perr_skip_setup: got perr=%b count=%0d want 1/0", protocol_err, count);
    end
    clear_err = 1; cyc(); clear_err = 0;
    checks++;
    if (protocol_err !== 0) begin
      errors++; $display("FAIL perr_clear: got perr=%b want 0", protocol_err);
    end
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h80; cyc();
    penable = 1; pready = 0; cyc();
    paddr = 32'h84; pready = 1; cyc();
    bus_idle(); bus_idle();
    checks++;
    if (protocol_err !== 1 || count !== '0 || txn_valid !== 0) begin
      errors++;
      $display("FAIL perr_addr_change: got perr=%b count=%0d valid=%b want 1/0/0", protocol_err, count, txn_valid);
    end
    psel = 0; penable = 1; clear_err = 1; cyc();
    penable = 0; clear_err = 0;
    checks++;
    if (protocol_err !== 1) begin
      errors++; $display("FAIL perr_set_wins: got perr=%b want 1", protocol_err);
    end
    clear_err = 1; cyc(); clear_err = 0;
    psel = 1; penable = 0; paddr = 32'h90; cyc();
    penable = 1; cyc();
    psel = 0; penable = 0; cyc();
    checks++;
    if (protocol_err !== 1 || count !== '0) begin
      errors++; $display("FAIL perr_psel_drop: got perr=%b count=%0d want 1/0", protocol_err, count);
    end
    clear_err = 1; cyc(); clear_err = 0;
  endtask

  task automatic test_reset_mid();
    xfer(1, 32'h300, 32'h1, 0, 0, 0);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h304; cyc();
    penable = 1; pready = 0; cyc(); cyc();
    #2 preset_n = 0; #1;
    checks++;
    if ({txn_valid, count, overflow, protocol_err, txn_write, txn_addr, txn_data, txn_slverr, txn_wait} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got valid=%b count=%0d a=%h perr=%b want all 0",
               txn_valid, count, txn_addr, protocol_err);
    end
    psel = 0; penable = 0; cyc(); preset_n = 1; cyc();
    exp_q.delete(); exp_ovf = 0;
    xfer(0, 32'h308, 32'h5555_AAAA, 0, 0, 0);
    checks++;
    if (txn_wait !== '0 || count !== CW'(1) || protocol_err !== 0 || txn_addr !== 32'h308) begin
      errors++;
      $display("FAIL reset_mid recovery: got wt=%0d count=%0d perr=%b a=%h want 0/1/0/308",
               txn_wait, count, protocol_err, txn_addr);
    end
    drain_and_check("reset_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      xfer($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 1), 0);
      if ($urandom_range(0, 2) == 0) bus_idle();
      if (exp_q.size() == DEPTH) begin
        bus_idle(); drain_and_check("random");
      end
    end
    xfer(0, 32'h5A5A_0000, 32'h0BAD_F00D, WMAX + 5, 0, 0);
    bus_idle();
    checks++;
    if (overflow !== exp_ovf || protocol_err !== 1'b0) begin
      errors++; $display("FAIL random flags: got ovf=%b perr=%b want %b/0", overflow, protocol_err, exp_ovf);
    end
    drain_and_check("random_sat");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_waits();
    test_overflow();
    test_full_push_pop();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slave_monitor_capture_fifo.md
Name: slave_monitor_capture_fifo

Overview:
Passive synthesizable capture stage that sits directly downstream of the slave monitor BFM on the same APB-style bus interface. It snoops the bus and decodes each completed transfer into a single record: direction, address, data, error and wait count. Records are buffered in a first-word-fall-through FIFO, and the monitor proxy drains them with a valid/ready handshake. Protocol violations and FIFO overflow are flagged as sticky status bits.

Parameters:
ADDR_WIDTH, 32, width of paddr and txn_addr
DATA_WIDTH, 32, width of pwdata/prdata/txn_data
DEPTH, 8, number of FIFO records; must be a power of 2 and at least 2
WAIT_WIDTH, 8, width of the wait-state counter (saturating)

Ports:
pclk  input  1  bus clock; all logic is on its rising edge
preset_n  input  1  asynchronous active-low reset
psel  input  1  slave select
penable  input  1  access phase
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  transfer address
pwdata  input  DATA_WIDTH  write data
prdata  input  DATA_WIDTH  read data
pready  input  1  slave ready
pslverr  input  1  slave error; valid when pready is high
txn_valid  output  1  FIFO head record is valid
txn_ready  input  1  consumer accepts the head record
txn_write  output  1  head record direction
txn_addr  output  ADDR_WIDTH  head record address
txn_data  output  DATA_WIDTH  pwdata for writes, prdata for reads
txn_slverr  output  1  head record error flag
txn_wait  output  WAIT_WIDTH  head record wait-state count
count  output  $clog2(DEPTH)+1  number of records held
overflow  output  1  sticky flag: a record was dropped because the FIFO was full
protocol_err  output  1  sticky flag: a bus protocol violation was seen
clear_err  input  1  synchronous clear of overflow and protocol_err

Behaviour:
- Reset (preset_n low, asynchronous): FSM goes to IDLE; FIFO empties; count=0; txn_valid=0; all txn_* outputs 0; overflow=0; protocol_err=0; wait counter=0.
- FSM states and transitions, evaluated every pclk edge:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS when psel=1 and penable=1. Address and control (paddr, pwrite, pwdata) are latched in SETUP.
  - ACCESS with pready=0: stay in ACCESS; wait counter increments and saturates at 2^WAIT_WIDTH-1.
  - ACCESS with pready=1: push a record. Next state is SETUP if psel=1 and penable=0 (back-to-back transfer), otherwise IDLE. Wait counter clears.
- Record contents:
  - write = latched pwrite; addr = latched paddr.
  - data = latched pwdata if write, otherwise prdata sampled in the pready cycle.
  - slverr = pslverr in the pready cycle.
  - wait = number of ACCESS cycles with pready=0 (0 means no wait states).
- protocol_err sets, with no record pushed in every case, when any of these occur:
  - penable=1 while psel=0, in any state. The FSM goes to IDLE.
  - psel=1 and penable=1 in IDLE (SETUP skipped). The FSM stays IDLE.
  - In ACCESS, paddr or pwrite differs from the latched value, or psel drops before pready. The transfer is abandoned and the FSM goes to IDLE.
- FIFO:
  - First-word-fall-through: the head record appears on txn_* in the cycle after it is pushed.
  - Pop occurs when txn_valid and txn_ready are both 1. txn_* outputs are undefined-stable (hold their last value) when txn_valid=0.
  - Push into a full FIFO with no pop in the same cycle: the record is dropped, overflow sets, count stays DEPTH.
  - Full with push and pop in the same cycle: both occur and count is unchanged.
  - Empty with push and txn_ready=1: no bypass; the record appears next cycle.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- clear_err=1 clears both sticky flags on the next edge. If a new error occurs in the same cycle as clear_err, the flag stays set (set wins).
- Reset asserted mid-transfer: the partial transfer is discarded, with no record and no error flag.

Test Plan:
- Single write, no wait: SETUP then ACCESS with pready=1, paddr=0x10, pwdata=0xA5A5_0001 -> one cycle later txn_valid=1, write=1, addr=0x10, data=0xA5A5_0001, wait=0, count=1.
- Read with 3 wait states, prdata=0xDEAD_BEEF, pslverr=1 on the final cycle -> record has write=0, data=0xDEAD_BEEF, slverr=1, wait=3.
- 10 back-to-back writes with txn_ready=0 at DEPTH=8 -> count=8, overflow=1, and draining returns addresses of transfers 1–8 in order. Then clear_err -> overflow=0.
- Full FIFO with simultaneous push and pop (txn_ready=1) -> count stays 8, overflow stays 0, pop/push order preserved.
- penable=1 in IDLE, then paddr changed mid-ACCESS -> protocol_err=1, count=0 throughout.
- Reset asserted during ACCESS wait states -> all outputs 0, and the next clean transfer is captured with wait=0.
